// File: rtl/tdm_demux_8_pkg.sv
// Shared definitions for the 8-slot TDM demultiplexer: frame geometry,
// FSM state encoding and a small bit-insert helper for the capture register.
package tdm_demux_8_pkg;

  // Slots per frame, which is also the width of the reassembled word.
  localparam int N  = 8;
  // Slot counter width. 2**CW must equal N so the counter covers 0..N-1 exactly.
  localparam int CW = 3;

  // Receiver FSM state. IDLE waits for a sync beat. RECV is collecting slots 1..N-1.
  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  // Return v with bit [idx] replaced by b. All other bits are unchanged.
  function automatic logic [N-1:0] set_bit(input logic [N-1:0] v,
                                           input logic [CW-1:0] idx,
                                           input logic          b);
    logic [N-1:0] r;
    r      = v;
    r[idx] = b;
    return r;
  endfunction

endpackage

// File: rtl/tdm_demux_8_if.sv
// Bus bundle for the TDM demultiplexer.
//
// Handshake: din_valid alone qualifies din and sync in the cycle it is high.
// There is no ready. Every valid beat is consumed on the rising edge it is
// presented. sync has no effect unless din_valid is also high. dout_valid and
// frame_err are single-cycle pulses. dout is stable between dout_valid pulses.
// state mirrors the receiver FSM so checkers can observe it directly.
interface tdm_demux_8_if;
  import tdm_demux_8_pkg::*;

  logic          din;
  logic          din_valid;
  logic          sync;
  logic [N-1:0]  dout;
  logic          dout_valid;
  logic [CW-1:0] slot;
  logic          busy;
  logic          frame_err;
  state_e        state;

  // Serial source side: drives the stream and observes the reassembled frames.
  modport master (
    output din, din_valid, sync,
    input  dout, dout_valid, slot, busy, frame_err, state
  );

  // Demultiplexer side.
  modport slave (
    input  din, din_valid, sync,
    output dout, dout_valid, slot, busy, frame_err, state
  );

endinterface

// File: rtl/tdm_demux_8_slot_ctr.sv
// Slot index counter for the TDM demultiplexer. It counts the next expected
// slot. clr returns it to 0 when a frame completes. load1 starts a fresh frame
// after its sync beat (slot 0) has been taken. last flags the final slot of
// the frame.
module tdm_demux_8_slot_ctr
  import tdm_demux_8_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic          load1,
  output logic [CW-1:0] count,
  output logic          last
);

  // Counter register. Priority is clear, then load-to-1, then increment.
  // Completion always clears, so the count never wraps past N-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load1) begin
      count <= CW'(1);
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign last = (count == CW'(N - 1));

endmodule

// File: rtl/tdm_demux_8.sv
// 8-slot, 1-bit TDM demultiplexer/deserializer. Each valid beat's din is placed
// at bit [slot] of a capture register. A sync beat always starts a new frame
// at slot 0. When slot N-1 is accepted, the completed capture is copied to dout
// on the following edge, together with a one-cycle dout_valid pulse. The FSM is
// already back in IDLE by then, so a sync beat in that same cycle starts the
// next frame with no dead cycle.
module tdm_demux_8
  import tdm_demux_8_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  tdm_demux_8_if.slave  bus
);

  state_e        state_q, state_d;
  logic [N-1:0]  cap_q, cap_d;
  logic [N-1:0]  dout_q;
  logic          dout_valid_q;
  logic          frame_err_q, frame_err_d;
  logic          done_q, done_d;

  logic          ctr_en, ctr_clr, ctr_load1;
  logic [CW-1:0] slot_cnt;
  logic          slot_last;

  logic          sync_beat;
  logic          data_beat;

  // A sync beat takes priority over data. A sync without din_valid is no beat.
  assign sync_beat = bus.din_valid &  bus.sync;
  assign data_beat = bus.din_valid & ~bus.sync;

  tdm_demux_8_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ctr_en),
    .clr   (ctr_clr),
    .load1 (ctr_load1),
    .count (slot_cnt),
    .last  (slot_last)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, capture update and counter controls for each accepted beat.
  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    ctr_en      = 1'b0;
    ctr_clr     = 1'b0;
    ctr_load1   = 1'b0;
    done_d      = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Only a sync beat opens a frame. Plain data beats are ignored here.
        if (sync_beat) begin
          cap_d     = {{(N-1){1'b0}}, bus.din};
          ctr_load1 = 1'b1;
          state_d   = RECV;
        end
      end

      RECV: begin
        if (sync_beat) begin
          // Resync mid-frame: drop the partial frame and flag it. The sync
          // beat becomes slot 0 of the new frame.
          frame_err_d = 1'b1;
          cap_d       = {{(N-1){1'b0}}, bus.din};
          ctr_load1   = 1'b1;
        end else if (data_beat) begin
          cap_d = set_bit(cap_q, slot_cnt, bus.din);
          if (slot_last) begin
            ctr_clr = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ctr_en = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture register and the one-cycle pulses for completion and abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q       <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cap_q       <= cap_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Output word: loaded only from a fully captured frame, one edge after the
  // last slot. It holds its value otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= done_q;
      if (done_q) begin
        dout_q <= cap_q;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.slot       = slot_cnt;
  assign bus.busy       = (state_q == RECV);
  assign bus.frame_err  = frame_err_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_tdm_demux_8.sv
// Bench for tdm_demux_8. A beat-level reference model predicts every output
// after every clock edge. Directed frames come first, then a random stream.
module tb_tdm_demux_8;
  import tdm_demux_8_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tdm_demux_8_if bus ();

  tdm_demux_8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_checks;
  int n_errors;

  // Reference model: the slot index of the next expected bit (0 = no frame
  // open), the bits gathered so far, and the queue of finished frames that
  // are due on dout one edge later.
  int           m_idx;
  logic [N-1:0] m_bits;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp_dout;
  logic         exp_dv;
  logic         exp_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx    = 0;
    m_bits   = '0;
    exp_q.delete();
    exp_dout = '0;
    exp_dv   = 1'b0;
    exp_err  = 1'b0;
  endtask

  // Apply one sampled beat to the model.
  task automatic model_step(input logic v, input logic s, input logic d);
    exp_dv  = 1'b0;
    exp_err = 1'b0;
    if (exp_q.size() > 0) begin
      exp_dout = exp_q.pop_front();
      exp_dv   = 1'b1;
    end
    if (v && s) begin
      exp_err   = (m_idx != 0);
      m_bits    = '0;
      m_bits[0] = d;
      m_idx     = 1;
    end else if (v && m_idx != 0) begin
      m_bits[m_idx] = d;
      m_idx++;
      if (m_idx == N) begin
        exp_q.push_back(m_bits);
        m_idx = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("dout_valid", 32'(bus.dout_valid), 32'(exp_dv));
    check_val("frame_err",  32'(bus.frame_err),  32'(exp_err));
    check_val("dout",       32'(bus.dout),       32'(exp_dout));
    check_val("slot",       32'(bus.slot),       32'(m_idx));
    check_val("busy",       32'(bus.busy),       32'(m_idx != 0));
  endtask

  // ---------------- driver tasks ----------------
  // Present one cycle of input, clock it in, then compare shortly after the edge.
  task automatic drive_beat(input logic v, input logic s, input logic d);
    bus.din_valid = v;
    bus.sync      = s;
    bus.din       = d;
    @(posedge clk);
    model_step(v, s, d);
    #1;
    check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_beat(1'b0, 1'b0, 1'b0);
  endtask

  // Send frame f (slot k -> bit k). The sync beat carries slot 0. For each
  // bit set in stall_mask, two stall cycles follow that slot's beat.
  task automatic send_frame(input logic [N-1:0] f, input logic [N-1:0] stall_mask);
    for (int k = 0; k < N; k++) begin
      drive_beat(1'b1, (k == 0), f[k]);
      if (stall_mask[k]) idle_cycles(2);
    end
  endtask

  // Assert reset between clock edges. The outputs must clear without an edge.
  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("rst_dout", 32'(bus.dout),       32'h0);
    check_val("rst_slot", 32'(bus.slot),       32'h0);
    check_val("rst_busy", 32'(bus.busy),       32'h0);
    check_val("rst_dv",   32'(bus.dout_valid), 32'h0);
    bus.din_valid = 1'b0;
    bus.sync      = 1'b0;
    bus.din       = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    rst_n         = 1'b0;
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.sync      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_dout",  32'(bus.dout),       32'h0);
    check_val("reset_dv",    32'(bus.dout_valid), 32'h0);
    check_val("reset_slot",  32'(bus.slot),       32'h0);
    check_val("reset_busy",  32'(bus.busy),       32'h0);
    check_val("reset_err",   32'(bus.frame_err),  32'h0);
    check_val("reset_state", 32'(bus.state),      32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Spurious input while IDLE: data without sync, then sync without valid.
    for (int i = 0; i < 10; i++) drive_beat(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++)  drive_beat(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    check_val("spur_state", 32'(bus.state), 32'(IDLE));

    // Nominal frame 1,1,0,0,1,1,0,1 -> 8'hB3.
    send_frame(8'hB3, 8'h00);
    idle_cycles(1);
    check_val("nominal_dout", 32'(bus.dout), 32'hB3);
    idle_cycles(2);

    // Same frame with two-cycle stalls after slots 2 and 5.
    send_frame(8'hB3, 8'b0010_0100);
    idle_cycles(3);

    // Back-to-back frames with no gap.
    send_frame(8'hB3, 8'h00);
    send_frame(8'h5A, 8'h00);
    idle_cycles(1);
    check_val("b2b_dout", 32'(bus.dout), 32'h5A);
    idle_cycles(2);

    // Resync: four beats of a frame, then a new sync starting 8'h3C.
    drive_beat(1'b1, 1'b1, 1'b1);
    drive_beat(1'b1, 1'b0, 1'b0);
    drive_beat(1'b1, 1'b0, 1'b1);
    drive_beat(1'b1, 1'b0, 1'b1);
    send_frame(8'h3C, 8'h00);
    idle_cycles(1);
    check_val("resync_dout", 32'(bus.dout), 32'h3C);
    idle_cycles(2);

    // Reset in the middle of a frame after three beats.
    drive_beat(1'b1, 1'b1, 1'b1);
    drive_beat(1'b1, 1'b0, 1'b1);
    drive_beat(1'b1, 1'b0, 1'b1);
    async_reset();
    idle_cycles(4);

    // Random stream: mixed stalls, frames, aborts and sync-without-valid.
    for (int i = 0; i < 1500; i++) begin
      logic v, s, d;
      v = ($urandom_range(0, 9) < 7);
      s = v ? ($urandom_range(0, 11) == 0) : 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      drive_beat(v, s, d);
      if (i == 700) begin
        async_reset();
      end
    end
    idle_cycles(3);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
